// File: rtl/led_pkg.sv
// Shared definitions for the LED sequencer: pattern codes, controller
// states, rate field width and the step-period helper.
package led_pkg;

    localparam int RATE_W = 2;

    typedef enum logic [1:0] {
        PAT_OFF    = 2'd0,
        PAT_BLINK  = 2'd1,
        PAT_CHASE  = 2'd2,
        PAT_BOUNCE = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Step period in clock cycles; never zero so fast rates still advance.
    function automatic logic [31:0] step_period(input logic [31:0] clk_freq,
                                                input logic [RATE_W-1:0] rate);
        logic [31:0] p;
        p = clk_freq >> rate;
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

endpackage

// File: rtl/led_seq_ctrl_tick_gen.sv
// Free-running step counter: counts 0..period-1 while enabled and raises
// tick on the cycle whose closing edge wraps it back to 0.
module tick_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] period,
    output logic        tick
);

    logic [31:0] count;

    // A clear (new command or leaving RUN) suppresses the tick of that cycle.
    assign tick = enable && !clear && (count == (period - 32'd1));

    // Counter: held at zero when cleared or disabled, wraps on tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 32'd0;
        end else if (clear || !enable || tick) begin
            count <= 32'd0;
        end else begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer. A command (pattern + rate) is taken with a
// valid/ready handshake: the transfer happens on a rising edge where
// cmd_valid and cmd_ready are both 1; cmd_ready drops only for the single
// LOAD cycle that follows an accept, and the payload is sampled on the
// accepting edge. In RUN the LED bank advances one step per tick.
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int NUM_LEDS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_pattern,
    input  logic [RATE_W-1:0]   cmd_rate,
    output logic [NUM_LEDS-1:0] led,
    output logic                step
);

    state_e              state;
    pattern_e            pat_q;
    logic [RATE_W-1:0]   rate_q;
    logic                dir_up;
    logic                accept;
    logic                tick;
    logic                cnt_clear;
    logic                cnt_enable;
    logic [31:0]         period;
    logic [NUM_LEDS-1:0] init_led;
    logic [NUM_LEDS-1:0] next_led;
    logic                next_dir_up;

    assign accept     = cmd_valid && cmd_ready;
    assign cnt_enable = (state == ST_RUN);
    assign cnt_clear  = accept || (state != ST_RUN);
    assign period     = step_period(32'(CLK_FREQ), rate_q);

    tick_gen u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .period (period),
        .tick   (tick)
    );

    // Starting LED image for the latched pattern.
    always_comb begin
        init_led = '0;
        case (pat_q)
            PAT_BLINK:              init_led = '1;
            PAT_CHASE, PAT_BOUNCE:  init_led[0] = 1'b1;
            default:                init_led = '0;
        endcase
    end

    // Next LED image and bounce direction for one step of the running pattern.
    always_comb begin
        next_led    = led;
        next_dir_up = dir_up;
        case (pat_q)
            PAT_BLINK: next_led = ~led;
            PAT_CHASE: next_led = {led[NUM_LEDS-2:0], led[NUM_LEDS-1]};
            PAT_BOUNCE: begin
                if (dir_up) begin
                    next_led = led << 1;
                    if (led[NUM_LEDS-2]) next_dir_up = 1'b0;
                end else begin
                    next_led = led >> 1;
                    if (led[1]) next_dir_up = 1'b1;
                end
            end
            default: next_led = '0;
        endcase
    end

    // Controller FSM with registered outputs; an accept always beats a step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            led       <= '0;
            step      <= 1'b0;
            cmd_ready <= 1'b1;
            dir_up    <= 1'b1;
            rate_q    <= '0;
            pat_q     <= PAT_OFF;
        end else begin
            step <= 1'b0;
            case (state)
                ST_IDLE: begin
                    led <= '0;
                    if (accept) begin
                        pat_q     <= pattern_e'(cmd_pattern);
                        rate_q    <= cmd_rate;
                        cmd_ready <= 1'b0;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    led       <= init_led;
                    dir_up    <= 1'b1;
                    cmd_ready <= 1'b1;
                    state     <= (pat_q == PAT_OFF) ? ST_IDLE : ST_RUN;
                end
                ST_RUN: begin
                    if (accept) begin
                        pat_q     <= pattern_e'(cmd_pattern);
                        rate_q    <= cmd_rate;
                        cmd_ready <= 1'b0;
                        state     <= ST_LOAD;
                    end else if (tick) begin
                        led    <= next_led;
                        dir_up <= next_dir_up;
                        step   <= 1'b1;
                    end
                end
                default: begin
                    led       <= '0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter: CLK_FREQ, default 100000000, clock cycles between pattern steps at rate 0.
REQ-002 Parameter: NUM_LEDS, default 8, LED bank width; legal range 2..16.
REQ-003 Port: clk  in  1  single clock, rising-edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: cmd_valid  in  1  command offered.
REQ-006 Port: cmd_ready  out  1  command may be accepted this cycle.
REQ-007 Port: cmd_pattern  in  2  0=OFF, 1=BLINK, 2=CHASE, 3=BOUNCE.
REQ-008 Port: cmd_rate  in  2  step period = CLK_FREQ >> cmd_rate.
REQ-009 Port: led  out  NUM_LEDS  registered LED bank drive.
REQ-010 Port: step  out  1  one-cycle pulse, high on the cycle led shows a new step value.

Function
REQ-011 States SHALL be IDLE, LOAD and RUN; reset enters IDLE.
REQ-012 Command accepted on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_pattern/cmd_rate latched on that edge; next state LOAD.
REQ-013 cmd_ready SHALL be 1 in IDLE and RUN and 0 in LOAD; a valid held through LOAD is accepted on the first cycle after LOAD.
REQ-014 LOAD lasts exactly one cycle; on its exit edge: led = initial value, tick counter = 0, direction = up; next state RUN, or IDLE for OFF.
REQ-015 Initial led values: OFF all 0; BLINK all 1; CHASE and BOUNCE bit 0 only.
REQ-016 Period P = max(1, CLK_FREQ >> rate), computed at 32-bit width; in RUN the counter counts 0..P-1, and on the edge where count = P-1 it wraps to 0, led advances, step=1.
REQ-017 First step occurs P cycles after RUN entry; step SHALL be 0 in IDLE and LOAD.
REQ-018 BLINK: led inverts all bits each step.
REQ-019 CHASE: one-hot rotates left one position per step; bit NUM_LEDS-1 wraps to bit 0.
REQ-020 BOUNCE: one-hot shifts toward MSB while direction = up; on reaching bit NUM_LEDS-1 direction flips to down; on reaching bit 0 it flips to up; end positions are shown once per pass (no dwell).
REQ-021 Accept coinciding with a step edge: the command wins; no step applied, step=0, counter cleared per REQ-014.
REQ-022 In IDLE led holds 0 and the counter is held at 0.

Reset
REQ-023 While reset=1, regardless of clk: state=IDLE, led=0, step=0, cmd_ready=1, counter=0, direction=up, latched rate=0, latched pattern=OFF.
REQ-024 Reset asserted mid-RUN or mid-LOAD SHALL take effect immediately and discard any pending or just-accepted command.

Structure
REQ-025 Shared package led_pkg holds the pattern encoding constants, the state encoding and the rate field width.
REQ-026 Sub-module tick_gen (inputs clk, reset, clear, enable, 32-bit period; output tick pulse) implements the REQ-016 counter; everything else stays in led_seq_ctrl.

Verification (CLK_FREQ=8, NUM_LEDS=4)
REQ-027 Reset held high for 3 cycles, then released -> led=0000, cmd_ready=1, step=0; no activity for 50 cycles.
REQ-028 CHASE, rate 0 -> led=0001 after LOAD, then 0010, 0100, 1000, 0001 at 8-cycle spacing, step pulsing once per change.
REQ-029 BOUNCE, rate 1 (P=4) -> 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010 at 4-cycle spacing.
REQ-030 BLINK, rate 3 (P=max(1,1)=1) -> led alternates 1111/0000 every cycle with step continuously 1.
REQ-031 Send CHASE, then send BLINK on the exact edge of a CHASE step -> no CHASE step, cmd_ready=0 for exactly one cycle, then led=1111.
REQ-032 Assert reset between clock edges mid-RUN -> led=0000 and cmd_ready=1 before the next rising edge.
